// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Resolves three pipeline events in fixed priority:
//   1. Data-memory wait (mem_block): freeze every stage until dm_ready.
//   2. Taken branch/jump in EX: redirect the PC and flush IF/ID and ID/EX.
//   3. Load-use hazard: hold PC and IF/ID for one cycle and inject a bubble.
// A two-state FSM (RUN / MEM_WAIT) tracks an outstanding memory access. If the
// access waits WAIT_LIMIT cycles, it is abandoned and mem_err is raised. mem_err
// stays set until reset. All outputs other than the registered state are
// combinational from the state and the current inputs.
//
// Parameters:
//   WAIT_LIMIT  maximum MEM_WAIT cycles before a timeout (>= 1)
//   CNT_W       width of the performance counters
//
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   dec_rs1_ad/dec_rs2_ad          ID source register addresses
//   dec_rs1_read/dec_rs2_read      ID instruction reads rs1 / rs2
//   ex_rd_ad/ex_rdEn/ex_DMread     EX destination, write enable, load flag
//   ex_branch_taken                taken branch/jump resolved in EX
//   mem_access/dm_req/dm_ready     MEM-stage data-memory handshake
//   pc_en .. mem_wb_en             stage register enables
//   if_id_flush/id_ex_flush        stage flushes
//   pc_redirect                    PC takes the branch target
//   rf_we_gate                     register-file write gate
//   mem_err                        sticky memory timeout flag
//   stall_cnt/flush_cnt            performance counters
//
// Configuration macro:
//   HAZ_PERF_CNT_EN  enables saturating stall/flush counters. When the macro is
//                    not defined, both counters read as zero.

module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       dec_rs1_ad,
  input  logic [4:0]       dec_rs2_ad,
  input  logic             dec_rs1_read,
  input  logic             dec_rs2_read,
  input  logic [4:0]       ex_rd_ad,
  input  logic             ex_rdEn,
  input  logic             ex_DMread,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  output logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_redirect,
  output logic             rf_we_gate,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The wait counter holds 0 .. WAIT_LIMIT-1. The timeout fires on its last value.
  localparam int unsigned    WC_W    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIMIT - 1);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_mem_err;
  logic            r_abandon;
  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic            w_load_use;
  logic            w_mem_block;
  logic            w_timeout;

  assign w_rs1_hit  = dec_rs1_read & (dec_rs1_ad == ex_rd_ad);
  assign w_rs2_hit  = dec_rs2_read & (dec_rs2_ad == ex_rd_ad);
  assign w_load_use = ex_DMread & ex_rdEn & (ex_rd_ad != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // r_abandon marks the single release cycle after a timeout. During that cycle
  // the stalled access is dropped, so it must not block the pipeline again.
  assign w_mem_block = mem_access & ~dm_ready & ~r_abandon;

  assign mem_err = r_mem_err;

  // Next-state logic, memory request and timeout detection
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    dm_req      = 1'b0;
    if (reset) begin
      w_state_nxt = ST_RUN;
      dm_req      = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          dm_req = mem_access & ~r_abandon;
          if (w_mem_block) begin
            w_state_nxt = ST_MEM_WAIT;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          dm_req = 1'b1;
          if (w_mem_block) begin
            if (r_wait_cnt == WC_LAST) begin
              w_timeout   = 1'b1;
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_MEM_WAIT;
            end
          end else begin
            // dm_ready: release in this same cycle
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          dm_req      = 1'b0;
        end
      endcase
    end
  end

  // Stage enables, flushes and write gate in priority mem_block > branch > load-use
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_redirect = 1'b0;
    rf_we_gate  = 1'b1;
    if (reset) begin
      rf_we_gate = 1'b0;
    end else if (w_mem_block) begin
      // Branch and load-use wait for the release cycle.
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_en  = 1'b0;
      mem_wb_en  = 1'b0;
      rf_we_gate = 1'b0;
    end else if (ex_branch_taken) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      // One-cycle bubble. The dependent instruction then gets the load data
      // through forwarding.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // State register, wait counter, sticky error and post-timeout release flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= {WC_W{1'b0}};
      r_mem_err  <= 1'b0;
      r_abandon  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_err <= r_mem_err | w_timeout;
      r_abandon <= w_timeout;
      // Clearing outside MEM_WAIT makes every entry start from zero.
      if ((r_state == ST_MEM_WAIT) && (w_state_nxt == ST_MEM_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end else begin
        r_wait_cnt <= {WC_W{1'b0}};
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Saturating counters of stall cycles (pc_en low) and flush cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (if_id_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with WAIT_LIMIT = 4.
// ctl packs {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,
//            pc_redirect,if_id_flush,id_ex_flush,rf_we_gate,dm_req}.
// Inputs change 1 ns after a rising edge. Outputs are sampled 2 ns later.

module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [9:0] C_IDLE    = 10'b1111100010;
  localparam logic [9:0] C_IDLE_RQ = 10'b1111100011;
  localparam logic [9:0] C_RESET   = 10'b1111100000;
  localparam logic [9:0] C_BUBBLE  = 10'b0011100110;
  localparam logic [9:0] C_BRANCH  = 10'b1111111110;
  localparam logic [9:0] C_FREEZE  = 10'b0000000001;
  localparam logic [9:0] C_REL_BR  = 10'b1111111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dec_rs1_ad, dec_rs2_ad, ex_rd_ad;
  logic        dec_rs1_read, dec_rs2_read, ex_rdEn, ex_DMread, ex_branch_taken;
  logic        mem_access, dm_ready;
  logic        dm_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, pc_redirect, rf_we_gate, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic [9:0]  ctl;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                pc_redirect, if_id_flush, id_ex_flush, rf_we_gate, dm_req};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_LIMIT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .dec_rs1_ad(dec_rs1_ad), .dec_rs2_ad(dec_rs2_ad),
    .dec_rs1_read(dec_rs1_read), .dec_rs2_read(dec_rs2_read),
    .ex_rd_ad(ex_rd_ad), .ex_rdEn(ex_rdEn), .ex_DMread(ex_DMread),
    .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect), .rf_we_gate(rf_we_gate), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [15:0] exp_cnt(input int v);
    return PERF ? 16'(v) : 16'd0;
  endfunction

  task automatic set_idle();
    dec_rs1_ad = 5'd0; dec_rs2_ad = 5'd0; dec_rs1_read = 1'b0; dec_rs2_read = 1'b0;
    ex_rd_ad = 5'd0; ex_rdEn = 1'b0; ex_DMread = 1'b0; ex_branch_taken = 1'b0;
    mem_access = 1'b0; dm_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_DMread = 1'b1; ex_rdEn = 1'b1; ex_rd_ad = 5'd5;
    dec_rs1_read = 1'b1; dec_rs1_ad = 5'd5;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    mem_access = 1'b1;
    ex_branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    if (ctl !== C_RESET) begin $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET); n_fail++; end
    n_cmp++;
    if (mem_err !== 1'b0) begin $display("FAIL reset_mem_err: got %b expected 0", mem_err); n_fail++; end
    n_cmp++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); n_fail++;
    end
    n_cmp++;
    step();
    reset = 1'b0;
    set_idle();
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL idle_ctl: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_load_use();
    step();
    set_load_use();
    dec_rs2_ad = 5'd7;
    #2;
    if (ctl !== C_BUBBLE) begin $display("FAIL lu_rs1_bubble: got %b expected %b", ctl, C_BUBBLE); n_fail++; end
    n_cmp++;
    exp_stall++;
    step();
    ex_DMread = 1'b0; ex_rdEn = 1'b0; ex_rd_ad = 5'd0;
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL lu_after: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    if (stall_cnt !== exp_cnt(exp_stall)) begin
      $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt(exp_stall)); n_fail++;
    end
    n_cmp++;
    step();
    set_idle();
    ex_DMread = 1'b1; ex_rdEn = 1'b1; ex_rd_ad = 5'd9;
    dec_rs1_read = 1'b1; dec_rs1_ad = 5'd3; dec_rs2_read = 1'b1; dec_rs2_ad = 5'd9;
    #2;
    if (ctl !== C_BUBBLE) begin $display("FAIL lu_rs2_bubble: got %b expected %b", ctl, C_BUBBLE); n_fail++; end
    n_cmp++;
    exp_stall++;
    step();
    dec_rs2_read = 1'b0;
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL lu_rs2_unread: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    step();
    dec_rs2_read = 1'b1; ex_rdEn = 1'b0;
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL lu_no_rden: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    step();
    ex_rdEn = 1'b1; ex_DMread = 1'b0;
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL lu_alu_no_stall: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    step();
    set_idle();
  endtask

  task automatic test_x0();
    step();
    ex_DMread = 1'b1; ex_rdEn = 1'b1; ex_rd_ad = 5'd0;
    dec_rs1_read = 1'b1; dec_rs1_ad = 5'd0; dec_rs2_read = 1'b1; dec_rs2_ad = 5'd0;
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL x0_no_stall: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    step();
    set_idle();
    #2;
    if (stall_cnt !== exp_cnt(exp_stall)) begin
      $display("FAIL x0_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt(exp_stall)); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_branch();
    step();
    ex_branch_taken = 1'b1;
    #2;
    if (ctl !== C_BRANCH) begin $display("FAIL br_flush: got %b expected %b", ctl, C_BRANCH); n_fail++; end
    n_cmp++;
    exp_flush++;
    step();
    ex_branch_taken = 1'b0;
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL br_after: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    if (flush_cnt !== exp_cnt(exp_flush)) begin
      $display("FAIL br_flush_cnt: got %0d expected %0d", flush_cnt, exp_cnt(exp_flush)); n_fail++;
    end
    n_cmp++;
    step();
    ex_branch_taken = 1'b1;
    set_load_use();
    #2;
    if (ctl !== C_BRANCH) begin $display("FAIL br_over_lu: got %b expected %b", ctl, C_BRANCH); n_fail++; end
    n_cmp++;
    exp_flush++;
    step();
    set_idle();
    #2;
    if (flush_cnt !== exp_cnt(exp_flush) || stall_cnt !== exp_cnt(exp_stall)) begin
      $display("FAIL br_cnts: got %0d/%0d expected %0d/%0d", flush_cnt, stall_cnt,
               exp_cnt(exp_flush), exp_cnt(exp_stall)); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_mem_wait();
    step();
    mem_access = 1'b1; dm_ready = 1'b1;
    #2;
    if (ctl !== C_IDLE_RQ) begin $display("FAIL mw_ready_nofreeze: got %b expected %b", ctl, C_IDLE_RQ); n_fail++; end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      step();
      mem_access = 1'b1; dm_ready = 1'b0;
      #2;
      if (ctl !== C_FREEZE) begin $display("FAIL mw_freeze%0d: got %b expected %b", i, ctl, C_FREEZE); n_fail++; end
      n_cmp++;
      exp_stall++;
    end
    step();
    dm_ready = 1'b1;
    #2;
    if (ctl !== C_IDLE_RQ) begin $display("FAIL mw_release: got %b expected %b", ctl, C_IDLE_RQ); n_fail++; end
    n_cmp++;
    step();
    set_idle();
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL mw_back_run: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    if (stall_cnt !== exp_cnt(exp_stall) || mem_err !== 1'b0) begin
      $display("FAIL mw_cnt_err: got %0d/%b expected %0d/0", stall_cnt, mem_err, exp_cnt(exp_stall)); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      step();
      mem_access = 1'b1; dm_ready = 1'b0; ex_branch_taken = 1'b1;
      set_load_use();
      #2;
      if (ctl !== C_FREEZE) begin $display("FAIL sim_freeze%0d: got %b expected %b", i, ctl, C_FREEZE); n_fail++; end
      n_cmp++;
      exp_stall++;
    end
    step();
    dm_ready = 1'b1;
    #2;
    if (ctl !== C_REL_BR) begin $display("FAIL sim_release_branch: got %b expected %b", ctl, C_REL_BR); n_fail++; end
    n_cmp++;
    exp_flush++;
    step();
    set_idle();
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL sim_back_run: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    if (stall_cnt !== exp_cnt(exp_stall) || flush_cnt !== exp_cnt(exp_flush)) begin
      $display("FAIL sim_cnts: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt,
               exp_cnt(exp_stall), exp_cnt(exp_flush)); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_timeout();
    // One RUN entry cycle plus four MEM_WAIT cycles are frozen.
    for (int i = 0; i < 5; i++) begin
      step();
      mem_access = 1'b1; dm_ready = 1'b0;
      #2;
      if (ctl !== C_FREEZE || mem_err !== 1'b0) begin
        $display("FAIL to_freeze%0d: got %b/%b expected %b/0", i, ctl, mem_err, C_FREEZE); n_fail++;
      end
      n_cmp++;
      exp_stall++;
    end
    step();
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL to_abandon: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
    if (mem_err !== 1'b1) begin $display("FAIL to_mem_err: got %b expected 1", mem_err); n_fail++; end
    n_cmp++;
    if (stall_cnt !== exp_cnt(exp_stall)) begin
      $display("FAIL to_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt(exp_stall)); n_fail++;
    end
    n_cmp++;
    step();
    set_idle();
    #2;
    if (ctl !== C_IDLE || mem_err !== 1'b1) begin
      $display("FAIL to_sticky: got %b/%b expected %b/1", ctl, mem_err, C_IDLE); n_fail++;
    end
    n_cmp++;
    step();
    reset = 1'b1;
    #2;
    if (mem_err !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      $display("FAIL to_reset_clear: got %b/%0d/%0d expected 0/0/0", mem_err, stall_cnt, flush_cnt); n_fail++;
    end
    n_cmp++;
    exp_stall = 0;
    exp_flush = 0;
    step();
    reset = 1'b0;
    #2;
    if (ctl !== C_IDLE) begin $display("FAIL to_after_reset: got %b expected %b", ctl, C_IDLE); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) begin
      step();
      mem_access = 1'b1; dm_ready = 1'b0;
    end
    step();
    reset = 1'b1;
    #2;
    if (ctl !== C_RESET) begin $display("FAIL rmw_reset_ctl: got %b expected %b", ctl, C_RESET); n_fail++; end
    n_cmp++;
    step();
    reset = 1'b0;
    set_idle();
    #2;
    if (ctl !== C_IDLE || mem_err !== 1'b0) begin
      $display("FAIL rmw_idle: got %b/%b expected %b/0", ctl, mem_err, C_IDLE); n_fail++;
    end
    n_cmp++;
    repeat (6) step();
    #2;
    if (mem_err !== 1'b0 || stall_cnt !== 16'd0) begin
      $display("FAIL rmw_no_err: got %b/%0d expected 0/0", mem_err, stall_cnt); n_fail++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_simultaneous();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum MEM_WAIT cycles before a timeout.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports dec_rs1_ad and dec_rs2_ad, input, 5 each: source addresses of the instruction in ID.
REQ-006 SHALL have ports dec_rs1_read and dec_rs2_read, input, 1 each: the ID instruction reads rs1 / rs2.
REQ-007 SHALL have ports ex_rd_ad (input, 5), ex_rdEn (input, 1) and ex_DMread (input, 1): destination, write-enable and load flag of the instruction in EX.
REQ-008 SHALL have port ex_branch_taken, input, 1: a taken branch or jump resolved in EX.
REQ-009 SHALL have ports mem_access (input, 1), dm_req (output, 1) and dm_ready (input, 1): MEM-stage load/store handshake with data memory.
REQ-010 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en and mem_wb_en, 1 each: stage register enables (pip_en per stage).
REQ-011 SHALL have outputs if_id_flush, id_ex_flush and pc_redirect, 1 each.
REQ-012 SHALL have outputs rf_we_gate (1), mem_err (1, sticky), and stall_cnt and flush_cnt (CNT_W each).

Function
REQ-013 SHALL implement a two-state FSM, RUN and MEM_WAIT; all other outputs are combinational from the state and the current inputs.
REQ-014 SHALL define load_use = ex_DMread & ex_rdEn & (ex_rd_ad != 0) & ((dec_rs1_read & dec_rs1_ad == ex_rd_ad) | (dec_rs2_read & dec_rs2_ad == ex_rd_ad)).
REQ-015 SHALL define mem_block = mem_access & !dm_ready.
REQ-016 SHALL, in RUN, drive dm_req = mem_access.
REQ-017 SHALL, in MEM_WAIT, drive dm_req = 1.
REQ-018 SHALL apply priority mem_block > ex_branch_taken > load_use.
REQ-019 SHALL, when mem_block holds in either state, drive all five enables to 0, drive rf_we_gate = 0 and suppress all flushes; from RUN it enters MEM_WAIT.
REQ-020 SHALL, in MEM_WAIT, when dm_ready = 1, release the freeze in that same cycle and evaluate branch and load-use as in RUN, then return to RUN.
REQ-021 SHALL, on a taken branch without mem_block, drive pc_redirect = 1, if_id_flush = 1 and id_ex_flush = 1 with all enables at 1; the branch penalty is 2 cycles.
REQ-022 SHALL, on load_use without a branch or mem_block, drive pc_en = 0, if_id_en = 0 and id_ex_flush = 1 (bubble) for exactly one cycle; the following cycle proceeds and forwarding supplies the operand.
REQ-023 SHALL, when no event is active, drive all enables = 1, rf_we_gate = 1 and all flushes/redirect = 0.
REQ-024 SHALL count MEM_WAIT cycles; on reaching WAIT_LIMIT it sets mem_err = 1, returns to RUN and releases the freeze for one cycle while the access is abandoned.
REQ-025 SHALL clear the wait counter on every entry to MEM_WAIT.
REQ-026 SHALL hold mem_err at 1 until reset.
REQ-027 SHALL hold ex_branch_taken and load_use stable during a freeze; they are acted on only in the release cycle.

Reset
REQ-028 SHALL, on reset, immediately set state = RUN, wait counter = 0, mem_err = 0, stall_cnt = 0 and flush_cnt = 0.
REQ-029 SHALL, while reset is high, drive enables = 1, flushes = 0, pc_redirect = 0, dm_req = 0 and rf_we_gate = 0.
REQ-030 SHALL, on reset asserted mid-MEM_WAIT, abandon the outstanding access without flagging mem_err.

Configuration
REQ-031 SHALL, with HAZ_PERF_CNT_EN defined, increment stall_cnt each cycle pc_en = 0 and flush_cnt each cycle if_id_flush = 1; both saturate at all-ones.
REQ-032 SHALL, without HAZ_PERF_CNT_EN, tie stall_cnt and flush_cnt to 0 and implement no counter registers.

Verification
REQ-033 SHALL cover load-use: ex: lw x5 (ex_DMread=1, ex_rdEn=1, ex_rd_ad=5); ID reads rs1=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_cnt=1.
REQ-034 SHALL cover the x0 exception: same as REQ-033 but ex_rd_ad=0 -> no stall.
REQ-035 SHALL cover a taken branch: ex_branch_taken=1 -> pc_redirect=1, if_id_flush=1, id_ex_flush=1 for one cycle; flush_cnt=1.
REQ-036 SHALL cover a memory wait: mem_access=1 with dm_ready low for 3 cycles, then high -> 3 frozen cycles with rf_we_gate=0, release in the dm_ready cycle, state back to RUN.
REQ-037 SHALL cover a timeout with WAIT_LIMIT=4: dm_ready never asserted -> mem_err=1 after 4 MEM_WAIT cycles; a reset pulse then clears mem_err and the counters.
REQ-038 SHALL cover simultaneous events: mem_block, ex_branch_taken and load_use all asserted -> freeze only; on dm_ready only the branch flush occurs, with no bubble.
